// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a serial transmitter through an IDLE/LAUNCH/WAIT_DONE launch FSM.
// Optional clear-to-send gating via `define UART_TX_FIFO_CTS_EN (adds cts_n input).
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef UART_TX_FIFO_CTS_EN
    input  logic                     cts_n,
`endif
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of 2 in 2..256");
    end

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE
    } state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    state_t        state_q, state_d;
    logic          first_wait_q, first_wait_d;
    logic          clear_to_send;
    logic          push;
    logic          pop;

`ifdef UART_TX_FIFO_CTS_EN
    logic cts_meta_q;
    logic cts_sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    always_comb clear_to_send = ~cts_sync_q;
`else
    always_comb clear_to_send = 1'b1;
`endif

    // full is registered, so a write coinciding with a pop from a full FIFO is still dropped
    always_comb begin
        push = wr_en & ~full_q;
        pop  = (state_q == IDLE) & ~empty_q & ~tx_busy & clear_to_send;
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d     = (count_d == CW'(DEPTH));
        empty_d    = (count_d == '0);
        overflow_d = wr_en & full_q;
        tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
    end

    always_comb begin
        state_d      = state_q;
        first_wait_d = first_wait_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d      = WAIT_DONE;
                first_wait_d = 1'b1;
            end
            WAIT_DONE: begin
                // First cycle only gives busy time to rise; a transmitter that never
                // raises busy releases the FSM on the second cycle.
                if (first_wait_q) begin
                    first_wait_d = 1'b0;
                end else if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                first_wait_d = 1'b0;
            end
        endcase
        tx_start_d = (state_d == LAUNCH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            overflow_q   <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            state_q      <= IDLE;
            first_wait_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            overflow_q   <= overflow_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            state_q      <= state_d;
            first_wait_q <= first_wait_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH=16) with a simple busy-for-N-cycles transmitter model.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy = 1'b0;
`ifdef UART_TX_FIFO_CTS_EN
    logic          cts_n = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // 0: never busy, 1: held busy, 2: busy for 20 cycles after each start
    int   mode = 0;
    int   busy_cnt = 0;
    logic start_seen = 1'b0;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef UART_TX_FIFO_CTS_EN
        .cts_n    (cts_n),
`endif
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (mode == 1) begin
            tx_busy = 1'b1;
        end else if (mode == 0) begin
            tx_busy  = 1'b0;
            busy_cnt = 0;
        end else begin
            if (busy_cnt > 0) busy_cnt--;
            if (start_seen) busy_cnt = 20;
            tx_busy = (busy_cnt != 0);
        end
        start_seen = tx_start;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_idx;
        int last_c;
        int extra;
        int found;

        // reset state
        step;
        step;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);

        // single byte latency: write at edge N, tx_start after edge N+1
        rst_n   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        step;
        wr_en = 1'b0;
        chk("lat_count1", 32'(count), 1);
        chk("lat_empty0", 32'(empty), 0);
        chk("lat_no_start_yet", 32'(tx_start), 0);
        step;
        chk("lat_start", 32'(tx_start), 1);
        chk("lat_data", 32'(tx_data), 32'h55);
        chk("lat_count0", 32'(count), 0);
        step;
        chk("lat_start_one_cycle", 32'(tx_start), 0);
        chk("lat_data_hold", 32'(tx_data), 32'h55);
        step;
        step;
        step;

        // fill with transmitter held busy, 17th write overflows
        mode = 1;
        for (int i = 0; i < 17; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            step;
            if (i == 14) chk("fill_not_full_15", 32'(full), 0);
            if (i == 15) begin
                chk("fill_full_16", 32'(full), 1);
                chk("fill_no_ovf_16", 32'(overflow), 0);
            end
        end
        wr_en = 1'b0;
        chk("ovf_pulse", 32'(overflow), 1);
        chk("ovf_count", 32'(count), DEPTH);
        step;
        chk("ovf_pulse_end", 32'(overflow), 0);
        chk("ovf_count_hold", 32'(count), DEPTH);

        // write while full in the same cycle as a pop
        mode    = 0;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        step;
        wr_en = 1'b0;
        chk("wp_overflow", 32'(overflow), 1);
        chk("wp_count", 32'(count), DEPTH - 1);
        chk("wp_full", 32'(full), 0);
        chk("wp_start", 32'(tx_start), 1);
        chk("wp_head", 32'(tx_data), 32'h00);

        // drain remaining bytes in order; the dropped 0xEE must never appear
        exp_idx = 1;
        for (int c = 0; c < 200 && exp_idx < 16; c++) begin
            step;
            if (tx_start) begin
                chk("drain_order", 32'(tx_data), 32'(exp_idx));
                exp_idx++;
            end
        end
        chk("drain_complete", 32'(exp_idx), 16);
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            step;
            if (tx_start) extra++;
        end
        chk("drain_no_extra", 32'(extra), 0);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);

        // burst with 20-cycle frames
        mode    = 2;
        exp_idx = 0;
        last_c  = 0;
        for (int c = 0; c < 400 && exp_idx < 8; c++) begin
            if (c < 8) begin
                wr_en   = 1'b1;
                wr_data = 8'(8'hA0 + c);
            end else begin
                wr_en = 1'b0;
            end
            step;
            if (tx_start) begin
                chk("burst_order", 32'(tx_data), 32'(8'hA0 + exp_idx));
                if (exp_idx > 0) chk("burst_gap_ge21", 32'((c - last_c) >= 21), 1);
                last_c = c;
                exp_idx++;
            end
        end
        wr_en = 1'b0;
        chk("burst_complete", 32'(exp_idx), 8);
        for (int c = 0; c < 30; c++) step;
        chk("burst_empty", 32'(empty), 1);

        // reset during the first of three queued frames; write in reset cycle ignored
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'hB1 + i);
            step;
        end
        wr_en = 1'b0;
        chk("mid_count2", 32'(count), 2);
        step;
        step;
        step;
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h77;
        step;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_start", 32'(tx_start), 0);
        chk("mid_rst_data", 32'(tx_data), 0);
        rst_n = 1'b1;
        wr_en = 1'b0;
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            step;
            if (tx_start) extra++;
        end
        chk("mid_no_start", 32'(extra), 0);
        chk("mid_still_empty", 32'(empty), 1);
        wr_en   = 1'b1;
        wr_data = 8'h99;
        step;
        wr_en = 1'b0;
        found = 0;
        for (int c = 0; c < 50 && found == 0; c++) begin
            step;
            if (tx_start) begin
                found = 1;
                chk("post_rst_data", 32'(tx_data), 32'h99);
            end
        end
        chk("post_rst_start_seen", 32'(found), 1);
        for (int c = 0; c < 30; c++) step;

`ifdef UART_TX_FIFO_CTS_EN
        // clear-to-send gating
        mode  = 0;
        cts_n = 1'b1;
        step;
        step;
        step;
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        step;
        wr_en = 1'b0;
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            step;
            if (tx_start) extra++;
        end
        chk("cts_blocked", 32'(extra), 0);
        chk("cts_count1", 32'(count), 1);
        cts_n = 1'b0;
        found = 0;
        for (int c = 0; c < 4 && found == 0; c++) begin
            step;
            if (tx_start) begin
                found = 1;
                chk("cts_data", 32'(tx_data), 32'h3C);
            end
        end
        chk("cts_start_within4", 32'(found), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO capacity in bytes; SHALL be a power of 2, range 2..256.
REQ-002 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst_n  input  1  reset; SHALL be synchronous and active-low.
REQ-004 wr_en  input  1  write strobe; one byte per cycle.
REQ-005 wr_data  input  8  byte to enqueue; sampled when wr_en=1.
REQ-006 full  output  1  high when count==DEPTH.
REQ-007 empty  output  1  high when count==0.
REQ-008 count  output  log2(DEPTH)+1  number of bytes stored.
REQ-009 overflow  output  1  one-cycle pulse when a write is dropped.
REQ-010 tx_start  output  1  start strobe to the downstream serial transmitter.
REQ-011 tx_data  output  8  byte presented to the transmitter; stable while tx_start=1.
REQ-012 tx_busy  input  1  transmitter busy; rises the cycle after an accepted tx_start and falls when the frame is complete.

Function
REQ-013 Storage SHALL be a circular buffer with wr_ptr and rd_ptr of log2(DEPTH) bits each; both pointers wrap from DEPTH-1 to 0.
REQ-014 A write with full=0 SHALL store wr_data at wr_ptr and advance wr_ptr at that edge.
REQ-015 A write with full=1 SHALL be dropped, leave storage and pointers unchanged, and pulse overflow high in the next cycle, even if a pop occurs in the same cycle.
REQ-016 The launch FSM SHALL have three states: IDLE, LAUNCH and WAIT_DONE.
REQ-017 IDLE -> LAUNCH SHALL occur when empty=0 and tx_busy=0; at that edge the FSM pops the head byte into the tx_data register, advances rd_ptr and sets tx_start=1.
REQ-018 tx_start SHALL be high for exactly the one cycle spent in LAUNCH.
REQ-019 LAUNCH -> WAIT_DONE SHALL be unconditional.
REQ-020 WAIT_DONE -> IDLE SHALL occur on the first cycle with tx_busy=0, excluding the first WAIT_DONE cycle, which only waits for busy to rise.
REQ-021 If tx_busy has not risen by the second WAIT_DONE cycle, the FSM SHALL return to IDLE; the byte is considered sent.
REQ-022 Latency: a byte written at edge N into an empty FIFO, with the FSM in IDLE and tx_busy=0, SHALL have tx_start=1 in the cycle following edge N+1.
REQ-023 A simultaneous write and pop SHALL leave count unchanged, with both pointers advancing.
REQ-024 count, full and empty SHALL be registered and SHALL reflect all pushes and pops at the same edge.
REQ-025 tx_data SHALL hold its last value outside LAUNCH.
REQ-026 Bytes SHALL leave in write order with no duplication and no loss, except for writes dropped under REQ-015.

Reset
REQ-027 rst_n=0 at a rising edge SHALL clear wr_ptr, rd_ptr, count, overflow and tx_start, and set tx_data=0 and the FSM to IDLE.
REQ-028 After reset, empty=1 and full=0; storage contents are not reset.
REQ-029 Reset mid-frame SHALL discard all queued bytes; the FSM SHALL ignore tx_busy until it reaches IDLE and tx_busy=0.
REQ-030 Writes in the reset cycle SHALL be ignored.

Configuration
REQ-031 Macro UART_TX_FIFO_CTS_EN, when defined, SHALL add input cts_n (1 bit, active-low clear-to-send), synchronised with a 2-flop synchroniser reset to 1.
REQ-032 With UART_TX_FIFO_CTS_EN defined, IDLE -> LAUNCH SHALL additionally require synchronised cts_n=0; a frame already launched SHALL always complete.
REQ-033 Without UART_TX_FIFO_CTS_EN, the cts_n port SHALL NOT exist and launch depends only on REQ-017.

Verification
REQ-034 Reset, then write 0x55 with tx_busy=0 -> tx_start pulses one cycle, 2 edges after the write, with tx_data=0x55; count returns to 0.
REQ-035 Hold tx_busy=1, write DEPTH+1 bytes 0x00..0x10 -> full=1 after 16 writes; the 17th write produces an overflow pulse; count=16.
REQ-036 Model the transmitter as busy for 20 cycles per frame; burst-write 0xA0..0xA7 -> tx_data sequence 0xA0..0xA7, tx_start pulses spaced at least 21 cycles apart.
REQ-037 With count=DEPTH, assert a write in the same cycle as a pop -> write dropped, overflow=1, count=DEPTH-1.
REQ-038 Queue 3 bytes, assert rst_n=0 during the first frame -> count=0, empty=1; no further tx_start until a new write.
REQ-039 With UART_TX_FIFO_CTS_EN defined and cts_n=1, write 0x3C -> no tx_start; drop cts_n to 0 -> tx_start within 4 cycles with tx_data=0x3C.
